// File: rtl/rr_pkg.sv
// Shared types and sizing for the register-rename front end.
// Physical/logical register widths, lane count and the renamed-lane record.
package rr_pkg;
    localparam int P_ADDR_W    = 7;
    localparam int L_REGISTERS = 32;
    localparam int L_ADDR_W    = 5;
    localparam int INSTR_COUNT = 2;

    typedef logic [P_ADDR_W-1:0] preg_t;
    typedef logic [L_ADDR_W-1:0] lreg_t;

    typedef struct packed {
        logic  lane_en;
        preg_t pdst;
        preg_t psrc1;
        preg_t psrc2;
        preg_t old_pdst;
        logic  old_vld;
    } renamed_lane_t;
endpackage

// File: rtl/rename_dep_check.sv
// Intra-group dependency resolution: overrides RAT reads with physical
// registers allocated by older lanes of the same group.
module rename_dep_check
    import rr_pkg::*;
(
    input  logic [INSTR_COUNT-1:0]          lane_en,
    input  logic [INSTR_COUNT-1:0]          dst_en,
    input  lreg_t [INSTR_COUNT-1:0]         dst,
    input  lreg_t [INSTR_COUNT-1:0]         src1,
    input  lreg_t [INSTR_COUNT-1:0]         src2,
    input  preg_t [INSTR_COUNT-1:0]         rat_src1,
    input  preg_t [INSTR_COUNT-1:0]         rat_src2,
    input  preg_t [INSTR_COUNT-1:0]         rat_dst,
    input  preg_t [INSTR_COUNT-1:0]         fl_pop_data,
    input  logic                            need_fl,
    output renamed_lane_t [INSTR_COUNT-1:0] lanes
);

    preg_t [INSTR_COUNT-1:0] old_s;
    logic                    wr_s;

    // Older lanes scanned in ascending order so the highest matching lane wins.
    always_comb begin
        lanes = '0;
        old_s = '0;
        wr_s  = 1'b0;
        for (int k = 0; k < INSTR_COUNT; k++) begin
            lanes[k].lane_en = lane_en[k];
            lanes[k].pdst    = fl_pop_data[k];
            lanes[k].psrc1   = rat_src1[k];
            lanes[k].psrc2   = rat_src2[k];
            old_s[k]         = rat_dst[k];
            for (int j = 0; j < k; j++) begin
                wr_s = lane_en[j] & dst_en[j];
                lanes[k].psrc1 = (wr_s && (dst[j] == src1[k])) ? fl_pop_data[j] : lanes[k].psrc1;
                lanes[k].psrc2 = (wr_s && (dst[j] == src2[k])) ? fl_pop_data[j] : lanes[k].psrc2;
                old_s[k]       = (wr_s && (dst[j] == dst[k]))  ? fl_pop_data[j] : old_s[k];
            end
            // A popped but unused register is handed back through old_pdst.
            if (need_fl) begin
                lanes[k].old_vld = 1'b1;
                if (lane_en[k] && dst_en[k]) begin
                    lanes[k].old_pdst = old_s[k];
                end else begin
                    lanes[k].old_pdst = fl_pop_data[k];
                end
            end else begin
                lanes[k].old_vld  = 1'b0;
                lanes[k].old_pdst = '0;
            end
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: speculative RAT, free-list pop and registered output.
// Optional RENAME_STALL_CNT_EN adds a saturating input-stall counter port.
module rename_stage
    import rr_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [INSTR_COUNT-1:0]                   in_lane_en,
    input  logic [INSTR_COUNT-1:0]                   in_dst_en,
    input  logic [INSTR_COUNT-1:0][L_ADDR_W-1:0]     in_dst,
    input  logic [INSTR_COUNT-1:0][L_ADDR_W-1:0]     in_src1,
    input  logic [INSTR_COUNT-1:0][L_ADDR_W-1:0]     in_src2,
    input  logic [INSTR_COUNT-1:0][P_ADDR_W-1:0]     fl_pop_data,
    input  logic                                     fl_valid,
    output logic                                     fl_pop,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [INSTR_COUNT-1:0]                   out_lane_en,
    output logic [INSTR_COUNT-1:0][P_ADDR_W-1:0]     out_pdst,
    output logic [INSTR_COUNT-1:0][P_ADDR_W-1:0]     out_psrc1,
    output logic [INSTR_COUNT-1:0][P_ADDR_W-1:0]     out_psrc2,
    output logic [INSTR_COUNT-1:0][P_ADDR_W-1:0]     out_old_pdst,
    output logic [INSTR_COUNT-1:0]                   out_old_vld
`ifdef RENAME_STALL_CNT_EN
    ,
    output logic [31:0]                              stall_cnt
`endif
);

    preg_t                           rat_r [L_REGISTERS];
    preg_t [INSTR_COUNT-1:0]         rat_src1_s;
    preg_t [INSTR_COUNT-1:0]         rat_src2_s;
    preg_t [INSTR_COUNT-1:0]         rat_dst_s;
    renamed_lane_t [INSTR_COUNT-1:0] lanes_s;
    renamed_lane_t [INSTR_COUNT-1:0] out_r;
    logic                            out_valid_r;
    logic                            need_fl_s;
    logic                            accept_s;

    assign need_fl_s = |(in_lane_en & in_dst_en);
    assign in_ready  = !rst && (!out_valid_r || out_ready) && (fl_valid || !need_fl_s);
    assign accept_s  = in_valid & in_ready;
    assign fl_pop    = accept_s & need_fl_s;

    // RAT read ports for both sources and the old destination of every lane.
    always_comb begin
        rat_src1_s = '0;
        rat_src2_s = '0;
        rat_dst_s  = '0;
        for (int k = 0; k < INSTR_COUNT; k++) begin
            rat_src1_s[k] = rat_r[in_src1[k]];
            rat_src2_s[k] = rat_r[in_src2[k]];
            rat_dst_s[k]  = rat_r[in_dst[k]];
        end
    end

    rename_dep_check u_dep_check (
        .lane_en     (in_lane_en),
        .dst_en      (in_dst_en),
        .dst         (in_dst),
        .src1        (in_src1),
        .src2        (in_src2),
        .rat_src1    (rat_src1_s),
        .rat_src2    (rat_src2_s),
        .rat_dst     (rat_dst_s),
        .fl_pop_data (fl_pop_data),
        .need_fl     (need_fl_s),
        .lanes       (lanes_s)
    );

    // RAT update; later lanes overwrite earlier ones on a shared destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L_REGISTERS; i++) begin
                rat_r[i] <= P_ADDR_W'(i);
            end
        end else if (accept_s) begin
            for (int k = 0; k < INSTR_COUNT; k++) begin
                if (in_lane_en[k] && in_dst_en[k]) begin
                    rat_r[in_dst[k]] <= fl_pop_data[k];
                end
            end
        end
    end

    // Output pipeline register toward dispatch/ROB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_r       <= lanes_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Unpack the registered lane records onto the flat output ports.
    always_comb begin
        out_valid = out_valid_r;
        for (int k = 0; k < INSTR_COUNT; k++) begin
            out_lane_en[k]  = out_r[k].lane_en;
            out_pdst[k]     = out_r[k].pdst;
            out_psrc1[k]    = out_r[k].psrc1;
            out_psrc2[k]    = out_r[k].psrc2;
            out_old_pdst[k] = out_r[k].old_pdst;
            out_old_vld[k]  = out_r[k].old_vld;
        end
    end

`ifdef RENAME_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where a valid group was refused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (in_valid && !in_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: sequential in-order rename model,
// directed test-plan groups followed by randomized traffic.
module tb_rename_stage;
    import rr_pkg::*;

    logic            clk, rst, in_valid, in_ready, fl_valid, fl_pop, out_valid, out_ready;
    logic [1:0]      in_lane_en, in_dst_en, out_lane_en, out_old_vld;
    logic [1:0][4:0] in_dst, in_src1, in_src2;
    logic [1:0][6:0] fl_pop_data, out_pdst, out_psrc1, out_psrc2, out_old_pdst;
`ifdef RENAME_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    rename_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_en(in_lane_en), .in_dst_en(in_dst_en), .in_dst(in_dst),
        .in_src1(in_src1), .in_src2(in_src2), .fl_pop_data(fl_pop_data),
        .fl_valid(fl_valid), .fl_pop(fl_pop), .out_valid(out_valid),
        .out_ready(out_ready), .out_lane_en(out_lane_en), .out_pdst(out_pdst),
        .out_psrc1(out_psrc1), .out_psrc2(out_psrc2), .out_old_pdst(out_old_pdst),
        .out_old_vld(out_old_vld)
`ifdef RENAME_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     stamp;
        logic [1:0]      len, dv, ovld;
        logic [1:0][6:0] pdst, ps1, ps2, old;
    } exp_t;

    exp_t sbq[$];
    int   rat_m[32];
    int   fq[$];
    int   total = 0, bad = 0, cyc_n = 0, stall_m = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat_m[i] = i;
        fq.delete();
        for (int i = 32; i < 128; i++) fq.push_back(i);
        sbq.delete();
        stall_m = 0;
    endtask

    // One clock of stimulus; expected response is queued for the monitor.
    task automatic cyc(input logic v, input logic [1:0] le, input logic [1:0] de,
                       input logic [1:0][4:0] d, input logic [1:0][4:0] s1,
                       input logic [1:0][4:0] s2, input logic fv, input logic ordy);
        exp_t e;
        logic need, exp_rdy, acc;
        int   cr[32];
        int   fl[2];
        @(negedge clk);
        cyc_n++;
        in_valid = v; in_lane_en = le; in_dst_en = de; in_dst = d;
        in_src1 = s1; in_src2 = s2; fl_valid = fv; out_ready = ordy;
        fl[0] = fq[0]; fl[1] = fq[1];
        fl_pop_data[0] = 7'(fl[0]);
        fl_pop_data[1] = 7'(fl[1]);
        #1;
        need    = |(le & de);
        exp_rdy = ((sbq.size() == 0) || ordy) && (fv || !need);
        acc     = v && exp_rdy;
        chk("in_ready", in_ready, exp_rdy);
        chk("fl_pop", fl_pop, acc && need);
        if (v && !exp_rdy) stall_m++;
        if (acc) begin
            cr = rat_m;
            e = '0;
            e.stamp = cyc_n; e.len = le; e.dv = de;
            for (int k = 0; k < 2; k++) begin
                e.ps1[k] = 7'(cr[s1[k]]);
                e.ps2[k] = 7'(cr[s2[k]]);
                if (need) begin
                    e.ovld[k] = 1'b1;
                    if (le[k] && de[k]) begin
                        e.old[k]  = 7'(cr[d[k]]);
                        e.pdst[k] = 7'(fl[k]);
                        cr[d[k]]  = fl[k];
                    end else begin
                        e.old[k] = 7'(fl[k]);
                    end
                end
            end
            rat_m = cr;
            if (need) begin
                void'(fq.pop_front());
                void'(fq.pop_front());
            end
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 2'b00, 10'd0, 10'd0, 10'd0, 1'b1, 1'b1);
    endtask

    task automatic rnd_cyc();
        cyc(($urandom % 4) != 0, 2'($urandom), 2'($urandom), 10'($urandom),
            10'($urandom), 10'($urandom), ($urandom % 5) != 0, ($urandom % 3) != 0);
    endtask

    // Monitor: compares the presented group with the scoreboard head.
    initial begin
        exp_t me;
        logic exp_v;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            exp_v = (sbq.size() > 0) && (sbq[0].stamp < cyc_n);
            chk("out_valid", out_valid, exp_v);
            if (exp_v) begin
                me = sbq[0];
                if (out_valid) begin
                    chk("out_lane_en", out_lane_en, me.len);
                    chk("out_old_vld", out_old_vld, me.ovld);
                    for (int k = 0; k < 2; k++) begin
                        if (me.len[k]) begin
                            chk("out_psrc1", out_psrc1[k], me.ps1[k]);
                            chk("out_psrc2", out_psrc2[k], me.ps2[k]);
                        end
                        if (me.len[k] && me.dv[k]) chk("out_pdst", out_pdst[k], me.pdst[k]);
                        if (me.ovld[k]) chk("out_old_pdst", out_old_pdst[k], me.old[k]);
                    end
                end
                if (out_ready) begin
                    void'(sbq.pop_front());
                    for (int k = 0; k < 2; k++)
                        if (me.ovld[k]) fq.push_back(int'(me.old[k]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_lane_en = 2'b11; in_dst_en = 2'b11;
        in_dst = 10'd0; in_src1 = 10'd0; in_src2 = 10'd0; fl_pop_data = 14'd0;
        fl_valid = 1'b1; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_lane_en", out_lane_en, 0);
        chk("rst_out_old_vld", out_old_vld, 0);
        chk("rst_out_pdst", out_pdst, 0);
        chk("rst_fl_pop", fl_pop, 0);
        in_valid = 1'b0;
        rst = 1'b0;

        // dst r3 src r1,r2 ; dst r4 src r3,r3
        cyc(1'b1, 2'b11, 2'b11, {5'd4, 5'd3}, {5'd3, 5'd1}, {5'd3, 5'd2}, 1'b1, 1'b1);
        idle();
        // both lanes write r5, then read r5
        cyc(1'b1, 2'b11, 2'b11, {5'd5, 5'd5}, {5'd0, 5'd0}, {5'd1, 5'd1}, 1'b1, 1'b1);
        cyc(1'b1, 2'b11, 2'b00, {5'd0, 5'd0}, {5'd5, 5'd5}, {5'd5, 5'd0}, 1'b1, 1'b1);
        // lane1 without destination returns its popped register
        cyc(1'b1, 2'b11, 2'b01, {5'd0, 5'd7}, {5'd7, 5'd2}, {5'd3, 5'd4}, 1'b1, 1'b1);
        // downstream stall for 3 cycles
        cyc(1'b1, 2'b11, 2'b11, {5'd8, 5'd6}, {5'd6, 5'd5}, {5'd7, 5'd4}, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 2'b11, 2'b11, {5'd9, 5'd9}, {5'd6, 5'd8}, {5'd9, 5'd1}, 1'b1, 1'b0);
        idle();
`ifdef RENAME_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_m);
`endif
        // empty free list: dst group stalls, no-dst group passes
        cyc(1'b1, 2'b11, 2'b10, {5'd9, 5'd0}, {5'd8, 5'd6}, {5'd9, 5'd1}, 1'b0, 1'b1);
        cyc(1'b1, 2'b11, 2'b00, {5'd9, 5'd0}, {5'd8, 5'd6}, {5'd9, 5'd1}, 1'b0, 1'b1);
        idle();

        repeat (400) rnd_cyc();

        // reset with a group in flight
        cyc(1'b1, 2'b11, 2'b11, {5'd9, 5'd9}, {5'd1, 5'd2}, {5'd3, 5'd4}, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        model_reset();
        in_valid = 1'b1; in_lane_en = 2'b11; in_dst_en = 2'b11; fl_valid = 1'b1;
        #1;
        chk("midrst_fl_pop", fl_pop, 0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        cyc(1'b1, 2'b11, 2'b01, {5'd0, 5'd2}, {5'd9, 5'd9}, {5'd9, 5'd2}, 1'b1, 1'b1);
        repeat (100) rnd_cyc();
        repeat (3) idle();
`ifdef RENAME_STALL_CNT_EN
        chk("stall_cnt_final", stall_cnt, stall_m);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
